pipeline_ctrl: RTL and testbench

- Central pipeline controller. Generates the load and flush strobes for every stage register: IF/ID, ID/EX (the ID-to-EX register carrying pc, rs1/rs2 values, jmp_pc, pc_mux_sel), EX/MEM and MEM/WB.
- Consumes the EX-stage outputs of the ID/EX register: EX_pc_mux_sel, plus EX mem-read and rd.
- Drives back the load strobes those registers sample.
- Handles cache-miss freeze with split I/D response tracking, load-use bubbles, taken-branch squash and saturating performance counters.

---
 rtl/pipeline_ctrl.sv | 115 +++++++++++
 tb/tb_pipeline_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - pipeline stage load/flush controller with cache freeze, hazards and counters
// Combinational load/flush strobes; registered RUN/WAIT state, per-side done flags and saturating counters.
module pipeline_ctrl #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 EX_pc_mux_sel,
    input  logic                 EX_mem_read,
    input  logic [4:0]           EX_rd,
    input  logic [4:0]           ID_rs1,
    input  logic [4:0]           ID_rs2,
    input  logic                 ID_uses_rs1,
    input  logic                 ID_uses_rs2,
    input  logic                 icache_read,
    input  logic                 icache_resp,
    input  logic                 dcache_req,
    input  logic                 dcache_resp,
    output logic                 load_pc,
    output logic                 load_IF_ID,
    output logic                 load_ID_EX,
    output logic                 load_EX_MEM,
    output logic                 load_MEM_WB,
    output logic                 flush_IF_ID,
    output logic                 flush_ID_EX,
    output logic                 state_wait,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic [CNT_WIDTH-1:0] flush_count
);

    localparam logic [0:0]           ST_RUN  = 1'b0;
    localparam logic [0:0]           ST_WAIT = 1'b1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [0:0]           r_state;
    logic                 r_i_done;
    logic                 r_d_done;
    logic [CNT_WIDTH-1:0] r_stall_cycles;
    logic [CNT_WIDTH-1:0] r_flush_count;

    logic w_i_ok;
    logic w_d_ok;
    logic w_advance;
    logic w_run;
    logic w_freeze;
    logic w_rs1_match;
    logic w_rs2_match;
    logic w_hazard;
    logic w_squash;
    logic w_bubble;
    logic w_stall_inc;

    // A side is satisfied if idle, completing now, or already completed earlier in this freeze.
    assign w_i_ok    = ~icache_read | icache_resp | r_i_done;
    assign w_d_ok    = ~dcache_req  | dcache_resp | r_d_done;
    assign w_advance = w_i_ok & w_d_ok;

    assign w_run    = ~reset &  w_advance;
    assign w_freeze = ~reset & ~w_advance;

    assign w_rs1_match = ID_uses_rs1 & (ID_rs1 == EX_rd);
    assign w_rs2_match = ID_uses_rs2 & (ID_rs2 == EX_rd);
    assign w_hazard    = EX_mem_read & (EX_rd != 5'd0) & (w_rs1_match | w_rs2_match);

    // A taken branch squashes the ID instruction, so its load-use hazard is moot.
    assign w_squash = w_run & EX_pc_mux_sel;
    assign w_bubble = w_run & ~EX_pc_mux_sel & w_hazard;

    assign load_pc     = w_run & ~w_bubble;
    assign load_IF_ID  = w_run & ~w_bubble;
    assign load_ID_EX  = w_run;
    assign load_EX_MEM = w_run;
    assign load_MEM_WB = w_run;
    assign flush_IF_ID = w_squash;
    assign flush_ID_EX = w_squash | w_bubble;

    assign w_stall_inc = w_freeze | w_bubble;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_RUN;
            r_i_done       <= 1'b0;
            r_d_done       <= 1'b0;
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (w_freeze) begin
                r_state <= ST_WAIT;
                if (icache_resp) begin
                    r_i_done <= 1'b1;
                end
                if (dcache_resp) begin
                    r_d_done <= 1'b1;
                end
            end else begin
                r_state  <= ST_RUN;
                r_i_done <= 1'b0;
                r_d_done <= 1'b0;
            end

            if (w_stall_inc && (r_stall_cycles != CNT_MAX)) begin
                r_stall_cycles <= r_stall_cycles + CNT_ONE;
            end
            if (w_squash && (r_flush_count != CNT_MAX)) begin
                r_flush_count <= r_flush_count + CNT_ONE;
            end
        end
    end

    assign state_wait   = (r_state == ST_WAIT);
    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;

    logic       clk;
    logic       reset;
    logic       EX_pc_mux_sel;
    logic       EX_mem_read;
    logic [4:0] EX_rd;
    logic [4:0] ID_rs1;
    logic [4:0] ID_rs2;
    logic       ID_uses_rs1;
    logic       ID_uses_rs2;
    logic       icache_read;
    logic       icache_resp;
    logic       dcache_req;
    logic       dcache_resp;

    logic        load_pc, load_IF_ID, load_ID_EX, load_EX_MEM, load_MEM_WB;
    logic        flush_IF_ID, flush_ID_EX, state_wait;
    logic [31:0] stall_cycles, flush_count;

    logic        load_pc3, load_IF_ID3, load_ID_EX3, load_EX_MEM3, load_MEM_WB3;
    logic        flush_IF_ID3, flush_ID_EX3, state_wait3;
    logic [2:0]  stall_cycles3, flush_count3;

    logic [6:0] w_ctrl;
    logic [6:0] w_ctrl3;
    assign w_ctrl  = {load_pc, load_IF_ID, load_ID_EX, load_EX_MEM, load_MEM_WB, flush_IF_ID, flush_ID_EX};
    assign w_ctrl3 = {load_pc3, load_IF_ID3, load_ID_EX3, load_EX_MEM3, load_MEM_WB3, flush_IF_ID3, flush_ID_EX3};

    pipeline_ctrl u_dut (
        .clk(clk), .reset(reset), .EX_pc_mux_sel(EX_pc_mux_sel), .EX_mem_read(EX_mem_read),
        .EX_rd(EX_rd), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_uses_rs1(ID_uses_rs1),
        .ID_uses_rs2(ID_uses_rs2), .icache_read(icache_read), .icache_resp(icache_resp),
        .dcache_req(dcache_req), .dcache_resp(dcache_resp), .load_pc(load_pc),
        .load_IF_ID(load_IF_ID), .load_ID_EX(load_ID_EX), .load_EX_MEM(load_EX_MEM),
        .load_MEM_WB(load_MEM_WB), .flush_IF_ID(flush_IF_ID), .flush_ID_EX(flush_ID_EX),
        .state_wait(state_wait), .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    pipeline_ctrl #(.CNT_WIDTH(3)) u_dut3 (
        .clk(clk), .reset(reset), .EX_pc_mux_sel(EX_pc_mux_sel), .EX_mem_read(EX_mem_read),
        .EX_rd(EX_rd), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_uses_rs1(ID_uses_rs1),
        .ID_uses_rs2(ID_uses_rs2), .icache_read(icache_read), .icache_resp(icache_resp),
        .dcache_req(dcache_req), .dcache_resp(dcache_resp), .load_pc(load_pc3),
        .load_IF_ID(load_IF_ID3), .load_ID_EX(load_ID_EX3), .load_EX_MEM(load_EX_MEM3),
        .load_MEM_WB(load_MEM_WB3), .flush_IF_ID(flush_IF_ID3), .flush_ID_EX(flush_ID_EX3),
        .state_wait(state_wait3), .stall_cycles(stall_cycles3), .flush_count(flush_count3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: pipeline outcome per cycle plus unbounded event counts.
    bit     m_i_done = 0;
    bit     m_d_done = 0;
    bit     m_wait   = 0;
    longint m_stall  = 0;
    longint m_flush  = 0;
    logic [6:0] exp_ctrl;
    bit     m_freeze, m_squash, m_bubble;

    function automatic longint sat(longint v, int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_eval();
        bit i_ok, d_ok, hz;
        i_ok = !icache_read || icache_resp || m_i_done;
        d_ok = !dcache_req || dcache_resp || m_d_done;
        hz = EX_mem_read && (EX_rd != 0) &&
             ((ID_uses_rs1 && ID_rs1 == EX_rd) || (ID_uses_rs2 && ID_rs2 == EX_rd));
        m_freeze = 0; m_squash = 0; m_bubble = 0;
        if (reset)                  exp_ctrl = 7'b0000000;
        else if (!(i_ok && d_ok)) begin exp_ctrl = 7'b0000000; m_freeze = 1; end
        else if (EX_pc_mux_sel)    begin exp_ctrl = 7'b1111111; m_squash = 1; end
        else if (hz)               begin exp_ctrl = 7'b0011101; m_bubble = 1; end
        else                        exp_ctrl = 7'b1111100;
    endtask

    task automatic model_commit();
        model_eval();
        if (reset) begin
            m_i_done = 0; m_d_done = 0; m_wait = 0; m_stall = 0; m_flush = 0;
        end else if (m_freeze) begin
            if (icache_resp) m_i_done = 1;
            if (dcache_resp) m_d_done = 1;
            m_wait = 1;
            m_stall++;
        end else begin
            m_i_done = 0; m_d_done = 0; m_wait = 0;
            if (m_squash) m_flush++;
            if (m_bubble) m_stall++;
        end
    endtask

    task automatic tick();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 0; EX_pc_mux_sel = 0; EX_mem_read = 0; EX_rd = 0; ID_rs1 = 0; ID_rs2 = 0;
        ID_uses_rs1 = 0; ID_uses_rs2 = 0; icache_read = 0; icache_resp = 0;
        dcache_req = 0; dcache_resp = 0;
    endtask

    task automatic reset_dut();
        idle_inputs();
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1; icache_read = 1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total++; if (w_ctrl !== 7'b0) begin bad++; $display("FAIL reset_ctrl c=%0d got=%b exp=0000000", c, w_ctrl); end
            if (c == 1) begin
                total++; if (state_wait !== 1'b0) begin bad++; $display("FAIL reset_wait got=%b exp=0", state_wait); end
                total++; if (stall_cycles !== 32'd0) begin bad++; $display("FAIL reset_stall got=%0d exp=0", stall_cycles); end
                total++; if (flush_count !== 32'd0) begin bad++; $display("FAIL reset_flush got=%0d exp=0", flush_count); end
            end
            tick();
        end
        reset = 0; icache_resp = 1;
        @(negedge clk);
        total++; if (w_ctrl !== 7'b1111100) begin bad++; $display("FAIL post_reset_ctrl got=%b exp=1111100", w_ctrl); end
        tick();
    endtask

    task automatic test_split_miss();
        reset_dut();
        icache_read = 1; dcache_req = 1;
        for (int c = 0; c <= 5; c++) begin
            icache_resp = (c == 5);
            dcache_resp = (c == 2);
            @(negedge clk);
            total++;
            if (w_ctrl !== ((c == 5) ? 7'b1111100 : 7'b0000000)) begin
                bad++; $display("FAIL split_ctrl c=%0d got=%b", c, w_ctrl);
            end
            if (c >= 1) begin
                total++; if (state_wait !== 1'b1) begin bad++; $display("FAIL split_wait c=%0d got=%b exp=1", c, state_wait); end
            end
            tick();
        end
        idle_inputs();
        @(negedge clk);
        total++; if (stall_cycles !== 32'd5) begin bad++; $display("FAIL split_stall got=%0d exp=5", stall_cycles); end
        total++; if (state_wait !== 1'b0) begin bad++; $display("FAIL split_wait_end got=%b exp=0", state_wait); end
        tick();
    endtask

    task automatic test_load_use();
        reset_dut();
        EX_mem_read = 1; EX_rd = 5; ID_rs1 = 3; ID_uses_rs1 = 1; ID_rs2 = 5; ID_uses_rs2 = 1;
        @(negedge clk);
        total++; if (w_ctrl !== 7'b0011101) begin bad++; $display("FAIL loaduse_ctrl got=%b exp=0011101", w_ctrl); end
        tick();
        EX_rd = 0;
        @(negedge clk);
        total++; if (stall_cycles !== 32'd1) begin bad++; $display("FAIL loaduse_stall got=%0d exp=1", stall_cycles); end
        total++; if (w_ctrl !== 7'b1111100) begin bad++; $display("FAIL loaduse_rd0_ctrl got=%b exp=1111100", w_ctrl); end
        tick();
        @(negedge clk);
        total++; if (stall_cycles !== 32'd1) begin bad++; $display("FAIL loaduse_rd0_stall got=%0d exp=1", stall_cycles); end
        tick();
    endtask

    task automatic test_branch_priority();
        reset_dut();
        EX_mem_read = 1; EX_rd = 7; ID_rs1 = 7; ID_uses_rs1 = 1; EX_pc_mux_sel = 1;
        @(negedge clk);
        total++; if (w_ctrl !== 7'b1111111) begin bad++; $display("FAIL branch_ctrl got=%b exp=1111111", w_ctrl); end
        tick();
        idle_inputs();
        @(negedge clk);
        total++; if (flush_count !== 32'd1) begin bad++; $display("FAIL branch_flush got=%0d exp=1", flush_count); end
        total++; if (stall_cycles !== 32'd0) begin bad++; $display("FAIL branch_stall got=%0d exp=0", stall_cycles); end
        tick();
    endtask

    task automatic test_branch_during_miss();
        reset_dut();
        EX_pc_mux_sel = 1; dcache_req = 1;
        for (int c = 0; c <= 3; c++) begin
            dcache_resp = (c == 3);
            @(negedge clk);
            total++;
            if (w_ctrl !== ((c == 3) ? 7'b1111111 : 7'b0000000)) begin
                bad++; $display("FAIL brmiss_ctrl c=%0d got=%b", c, w_ctrl);
            end
            tick();
        end
        idle_inputs();
        @(negedge clk);
        total++; if (flush_count !== 32'd1) begin bad++; $display("FAIL brmiss_flush got=%0d exp=1", flush_count); end
        total++; if (stall_cycles !== 32'd3) begin bad++; $display("FAIL brmiss_stall got=%0d exp=3", stall_cycles); end
        total++; if (state_wait !== 1'b0) begin bad++; $display("FAIL brmiss_wait got=%b exp=0", state_wait); end
        tick();
    endtask

    task automatic test_saturation();
        reset_dut();
        icache_read = 1;
        for (int c = 0; c < 9; c++) tick();
        @(negedge clk);
        total++; if (stall_cycles3 !== 3'd7) begin bad++; $display("FAIL sat_stall3 got=%0d exp=7", stall_cycles3); end
        total++; if (stall_cycles !== 32'd9) begin bad++; $display("FAIL sat_stall32 got=%0d exp=9", stall_cycles); end
        total++; if (state_wait !== 1'b1) begin bad++; $display("FAIL sat_wait got=%b exp=1", state_wait); end
        icache_resp = 1;
        tick();
        idle_inputs();
    endtask

    task automatic test_random();
        reset_dut();
        for (int n = 0; n < 400; n++) begin
            reset         = ($urandom_range(0, 39) == 0);
            icache_read   = ($urandom_range(0, 1) == 1);
            icache_resp   = ($urandom_range(0, 3) == 0);
            dcache_req    = ($urandom_range(0, 2) == 0);
            dcache_resp   = ($urandom_range(0, 3) == 0);
            EX_pc_mux_sel = ($urandom_range(0, 6) == 0);
            EX_mem_read   = ($urandom_range(0, 1) == 1);
            EX_rd         = 5'($urandom_range(0, 3));
            ID_rs1        = 5'($urandom_range(0, 3));
            ID_rs2        = 5'($urandom_range(0, 3));
            ID_uses_rs1   = ($urandom_range(0, 1) == 1);
            ID_uses_rs2   = ($urandom_range(0, 1) == 1);
            @(negedge clk);
            model_eval();
            total++; if (w_ctrl !== exp_ctrl) begin bad++; $display("FAIL rand_ctrl n=%0d got=%b exp=%b", n, w_ctrl, exp_ctrl); end
            total++; if (w_ctrl3 !== exp_ctrl) begin bad++; $display("FAIL rand_ctrl3 n=%0d got=%b exp=%b", n, w_ctrl3, exp_ctrl); end
            total++; if (state_wait !== m_wait) begin bad++; $display("FAIL rand_wait n=%0d got=%b exp=%b", n, state_wait, m_wait); end
            total++; if (longint'(stall_cycles) != sat(m_stall, 32)) begin bad++; $display("FAIL rand_stall n=%0d got=%0d exp=%0d", n, stall_cycles, sat(m_stall, 32)); end
            total++; if (longint'(flush_count) != sat(m_flush, 32)) begin bad++; $display("FAIL rand_flush n=%0d got=%0d exp=%0d", n, flush_count, sat(m_flush, 32)); end
            total++; if (longint'(stall_cycles3) != sat(m_stall, 3)) begin bad++; $display("FAIL rand_stall3 n=%0d got=%0d exp=%0d", n, stall_cycles3, sat(m_stall, 3)); end
            total++; if (longint'(flush_count3) != sat(m_flush, 3)) begin bad++; $display("FAIL rand_flush3 n=%0d got=%0d exp=%0d", n, flush_count3, sat(m_flush, 3)); end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        @(posedge clk);
        #1;
        test_reset();
        test_split_miss();
        test_load_use();
        test_branch_priority();
        test_branch_during_miss();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
